// File: rtl/lora_pkg.sv
// Shared LoRa UART constants and the transmitter FSM state type.
package lora_pkg;
  localparam int unsigned BPS_DIV_DEFAULT = 434;
  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned CNT_W           = 13;
  localparam logic        START_LVL       = 1'b0;
  localparam logic        STOP_LVL        = 1'b1;
  localparam logic        IDLE_LVL        = 1'b1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/lora_uart_tx_if.sv
// Byte handshake between the packet builder (master) and the UART transmitter (slave).
interface lora_uart_tx_if;
  import lora_pkg::*;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/lora_byte_fifo.sv
// Synchronous show-ahead byte FIFO with occupancy count; shared with the receive path.
module lora_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage needs no reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  assign rdata_c = mem[rd_ptr];
  assign full_c  = (level == LVL_W'(DEPTH));
  assign empty_c = (level == '0);
endmodule

// File: rtl/lora_uart_tx.sv
// 8N1 UART transmitter for the LoRa module TXD pin, fed through a small byte FIFO.
module lora_uart_tx
  import lora_pkg::*;
#(
  parameter int unsigned BPS_DIV    = BPS_DIV_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  lora_uart_tx_if.slave               tx,
  output logic                        txd,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int unsigned      LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BPS_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] head_c;
  logic [LVL_W-1:0]     lvl_n;
  logic                 ready, ready_n, busy_n, txd_n;
  logic                 push_c, pop_c, full_c, empty_c;

  assign tx.tx_ready = ready;
  assign push_c      = tx.tx_valid & ready & ~full_c;

  lora_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .wdata   (tx.tx_data),
    .pop     (pop_c),
    .rdata_c (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .level   (fifo_level)
  );

  // Next-state, bit timing and pop decision; txd follows the current state one cycle later.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop_c   = 1'b0;
    txd_n   = IDLE_LVL;
    if (state != IDLE) cnt_n = (cnt == BIT_LAST) ? '0 : cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_n = head_c;
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        txd_n = START_LVL;
        if (cnt == BIT_LAST) begin
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        txd_n = shift[0];
        if (cnt == BIT_LAST) begin
          shift_n = shift >> 1;
          idx_n   = idx + 3'(1);
          if (idx == IDX_LAST) state_n = STOP;
        end
      end
      STOP: begin
        txd_n = STOP_LVL;
        // Chain straight into the next start bit when more bytes are waiting.
        if (cnt == BIT_LAST) begin
          if (!empty_c) begin
            pop_c   = 1'b1;
            shift_n = head_c;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    lvl_n   = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
    busy_n  = (state_n != IDLE) || (lvl_n != '0);
    ready_n = (lvl_n != LVL_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      txd     <= IDLE_LVL;
      ready   <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      txd     <= txd_n;
      ready   <= ready_n;
      tx_busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_lora_uart_tx.sv
// Bench for lora_uart_tx: timeline reference model per instance (434 and 16 clocks/bit).
module tb_lora_uart_tx;
  localparam int unsigned NI    = 2;
  localparam int unsigned RING  = 64;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       drv_rst   [NI] = '{1'b1, 1'b1};
  logic       drv_valid [NI] = '{1'b0, 1'b0};
  logic [7:0] drv_data  [NI] = '{8'h00, 8'h00};
  logic       txd_a, txd_b, busy_a, busy_b;
  logic [2:0] lvl_a, lvl_b;

  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  lora_uart_tx_if if_a ();
  lora_uart_tx_if if_b ();
  assign if_a.tx_valid = drv_valid[0];
  assign if_a.tx_data  = drv_data[0];
  assign if_b.tx_valid = drv_valid[1];
  assign if_b.tx_data  = drv_data[1];

  lora_uart_tx #(.BPS_DIV(434), .FIFO_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(drv_rst[0]), .tx(if_a), .txd(txd_a), .tx_busy(busy_a), .fifo_level(lvl_a));
  lora_uart_tx #(.BPS_DIV(16), .FIFO_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(drv_rst[1]), .tx(if_b), .txd(txd_b), .tx_busy(busy_b), .fifo_level(lvl_b));

  always #5 clk = ~clk;

  // Model state: each accepted byte becomes a record with its accept and pop edge numbers.
  int unsigned r_acc [NI][RING];
  int unsigned r_pop [NI][RING];
  logic [7:0]  r_dat [NI][RING];
  int unsigned r_head [NI] = '{0, 0};
  int unsigned r_tail [NI] = '{0, 0};
  int unsigned last_pop [NI] = '{0, 0};
  bit          have_last [NI] = '{0, 0};
  int unsigned acc_cnt [NI] = '{0, 0};
  int unsigned last_acc [NI] = '{0, 0};
  bit          armed [NI] = '{0, 0};
  bit          exp_txd [NI] = '{1, 1};
  bit          exp_ready [NI] = '{0, 0};
  bit          exp_busy [NI] = '{0, 0};
  int unsigned exp_lvl [NI] = '{0, 0};

  function automatic int unsigned bdiv(input int i);
    return (i == 0) ? 434 : 16;
  endfunction
  function automatic logic get_txd(input int i);
    return (i == 0) ? txd_a : txd_b;
  endfunction
  function automatic logic get_busy(input int i);
    return (i == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic get_ready(input int i);
    return (i == 0) ? if_a.tx_ready : if_b.tx_ready;
  endfunction
  function automatic logic [2:0] get_lvl(input int i);
    return (i == 0) ? lvl_a : lvl_b;
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s[inst%0d] cyc=%0d got=%0h expected=%0h", name, i, cyc, got, expv);
    end
  endtask

  // A byte accepted at edge t pops at max(t+1, previous pop + 10 bit periods);
  // its line image after edge e in [pop+1, pop+10B] is bit (e-pop-1)/B of {start, d0..d7, stop}.
  task automatic model_step(input int i);
    int unsigned e = cyc;
    int unsigned b = bdiv(i);
    int unsigned p;
    int unsigned k2;
    int unsigned lvl = 0;
    bit act = 0;
    bit t = 1;
    if (drv_rst[i]) begin
      r_head[i] = r_tail[i];
      have_last[i] = 0;
      armed[i] = 1;
    end else if (armed[i] && drv_valid[i] && exp_ready[i]) begin
      p = e + 1;
      if (have_last[i] && last_pop[i] + 10 * b > p) p = last_pop[i] + 10 * b;
      r_acc[i][r_tail[i] % RING] = e;
      r_pop[i][r_tail[i] % RING] = p;
      r_dat[i][r_tail[i] % RING] = drv_data[i];
      r_tail[i]++;
      last_pop[i] = p;
      have_last[i] = 1;
      acc_cnt[i]++;
      last_acc[i] = e;
    end
    while (r_head[i] != r_tail[i] && r_pop[i][r_head[i] % RING] + 10 * b < e) r_head[i]++;
    for (int unsigned k = r_head[i]; k != r_tail[i]; k++) begin
      p = r_pop[i][k % RING];
      if (r_acc[i][k % RING] <= e && p > e) lvl++;
      if (p <= e && e < p + 10 * b) act = 1;
      if (e >= p + 1 && e <= p + 10 * b) begin
        k2 = (e - p - 1) / b;
        t = (k2 == 0) ? 1'b0 : (k2 == 9) ? 1'b1 : r_dat[i][k % RING][k2 - 1];
      end
    end
    exp_txd[i]   = t;
    exp_lvl[i]   = lvl;
    exp_ready[i] = (lvl < DEPTH);
    exp_busy[i]  = act || (lvl != 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) model_step(i);
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (armed[i]) begin
        check("txd", i, 32'(get_txd(i)), 32'(exp_txd[i]));
        check("fifo_level", i, 32'(get_lvl(i)), exp_lvl[i]);
        check("tx_ready", i, 32'(get_ready(i)), 32'(exp_ready[i]));
        check("tx_busy", i, 32'(get_busy(i)), 32'(exp_busy[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input int unsigned target);
    while (cyc < target) tick();
  endtask

  task automatic do_reset(input int i, input int unsigned n);
    drv_rst[i] = 1'b1;
    repeat (n) tick();
    drv_rst[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [7:0] d, output int unsigned at);
    int unsigned c0 = acc_cnt[i];
    int unsigned n = 0;
    drv_data[i] = d;
    drv_valid[i] = 1'b1;
    do begin
      tick();
      n++;
    end while (acc_cnt[i] == c0 && n < 20000);
    drv_valid[i] = 1'b0;
    check("send_accepted", i, 32'(acc_cnt[i] != c0), 32'd1);
    at = last_acc[i];
  endtask

  task automatic wait_idle(input int i);
    int unsigned n = 0;
    while (exp_busy[i] && n < 60000) begin
      tick();
      n++;
    end
    check("drain_bound", i, 32'(n < 60000), 32'd1);
    tick();
    check("busy_after_drain", i, 32'(get_busy(i)), 32'd0);
  endtask

  task automatic test_a();
    int unsigned n0, n1, at;
    logic seq55 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    do_reset(0, 3);
    check("rst_txd", 0, 32'(txd_a), 32'd1);
    check("rst_level", 0, 32'(lvl_a), 32'd0);
    check("rst_ready", 0, 32'(if_a.tx_ready), 32'd1);
    check("rst_busy", 0, 32'(busy_a), 32'd0);
    // Single 0x55 frame with literal bit images.
    send(0, 8'h55, n0);
    wait_edge(n0 + 1);
    check("x55_txd_still_idle", 0, 32'(txd_a), 32'd1);
    wait_edge(n0 + 2);
    check("x55_start_fall", 0, 32'(txd_a), 32'd0);
    for (int k = 0; k < 10; k++) begin
      wait_edge(n0 + 2 + 434 * k + 217);
      check("x55_bit", 0, 32'(txd_a), 32'(seq55[k]));
    end
    wait_edge(n0 + 4340);
    check("x55_busy_last", 0, 32'(busy_a), 32'd1);
    wait_edge(n0 + 4341);
    check("x55_busy_drop", 0, 32'(busy_a), 32'd0);
    wait_idle(0);
    // Back-to-back 0x00, 0xFF: no idle gap between frames.
    send(0, 8'h00, n0);
    send(0, 8'hFF, n1);
    check("b2b_accept", 0, n1, n0 + 1);
    wait_edge(n0 + 4341);
    check("b2b_stop_last", 0, 32'(txd_a), 32'd1);
    wait_edge(n0 + 4342);
    check("b2b_second_start", 0, 32'(txd_a), 32'd0);
    wait_edge(n0 + 4342 + 434 + 217);
    check("b2b_ff_d0", 0, 32'(txd_a), 32'd1);
    wait_edge(n0 + 8680);
    check("b2b_busy_last", 0, 32'(busy_a), 32'd1);
    wait_edge(n0 + 8681);
    check("b2b_busy_drop", 0, 32'(busy_a), 32'd0);
    wait_idle(0);
    // Six bytes held valid: FIFO fills to 4, sixth byte stalls until a pop.
    send(0, 8'hA0, n0);
    for (int k = 1; k < 5; k++) send(0, 8'(8'hA0 + k), at);
    check("fill_level", 0, 32'(lvl_a), 32'd4);
    check("fill_ready", 0, 32'(if_a.tx_ready), 32'd0);
    send(0, 8'hA5, at);
    check("a5_accept_edge", 0, at, n0 + 4342);
    wait_idle(0);
    // Push and pop on the same edge at level 2.
    send(0, 8'h11, n0);
    send(0, 8'h22, at);
    send(0, 8'h33, at);
    wait_edge(n0 + 4340);
    check("pp_level_before", 0, 32'(lvl_a), 32'd2);
    send(0, 8'h44, at);
    check("pp_accept_edge", 0, at, n0 + 4341);
    check("pp_level_after", 0, 32'(lvl_a), 32'd2);
    wait_idle(0);
    // Reset mid-frame with three bytes queued, then a clean 0x3C frame.
    send(0, 8'hC0, n0);
    for (int k = 1; k < 4; k++) send(0, 8'(8'hC0 + k), at);
    check("mid_level", 0, 32'(lvl_a), 32'd3);
    wait_edge(n0 + 2000);
    do_reset(0, 1);
    check("mid_rst_txd", 0, 32'(txd_a), 32'd1);
    check("mid_rst_level", 0, 32'(lvl_a), 32'd0);
    check("mid_rst_ready", 0, 32'(if_a.tx_ready), 32'd1);
    send(0, 8'h3C, n0);
    wait_edge(n0 + 2);
    check("x3c_start", 0, 32'(txd_a), 32'd0);
    wait_edge(n0 + 2 + 434 * 3 + 217);
    check("x3c_d2", 0, 32'(txd_a), 32'd1);
    wait_idle(0);
  endtask

  task automatic test_b();
    int unsigned n0, at;
    logic seq81 [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    do_reset(1, 3);
    send(1, 8'h81, n0);
    for (int k = 0; k < 10; k++) begin
      wait_edge(n0 + 2 + 16 * k);
      check("x81_bit_first", 1, 32'(txd_b), 32'(seq81[k]));
      wait_edge(n0 + 2 + 16 * k + 15);
      check("x81_bit_last", 1, 32'(txd_b), 32'(seq81[k]));
    end
    wait_idle(1);
    // Random bytes, random gaps (often none) and occasional resets.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(0, 40)) tick();
      if ($urandom_range(0, 49) == 0) do_reset(1, 1);
      send(1, 8'($urandom_range(0, 255)), at);
    end
    wait_idle(1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    fork
      test_a();
      test_b();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
